gpio_irq_conditioner: RTL

// - Fabric stage upstream of the MSS GPIO_31_IN interrupt pin; clocked by FAB_CCC_GL0 (CLK_BASE).
// - Debounces a raw push-button and raises a level interrupt request to the MSS.
// - Holds the request until firmware acknowledges it by pulsing GPIO_30_OUT (MSS_ACK).
// - Counts presses lost while a request is outstanding.

---
 rtl/gpio_irq_pkg.sv | 12 +
 rtl/gpio_debounce.sv | 43 ++++
 rtl/gpio_irq_conditioner.sv | 108 ++++++++++
 3 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared types and defaults for the GPIO interrupt conditioner.
package gpio_irq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam int unsigned MISS_CNT_W_DEF = 8;

endpackage

// File: rtl/gpio_debounce.sv
// Two-flop synchroniser and stable-count debouncer for an active-low push-button.
// Emits the debounced state and a one-cycle press pulse aligned with its rising edge.
module gpio_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_state,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             pressed_s;

    assign pressed_s = ~sync[1];

    // The counter tracks how long the synced input has disagreed with btn_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= 2'b11;
            cnt       <= '0;
            btn_state <= 1'b0;
            press     <= 1'b0;
        end else begin
            sync  <= {sync[0], btn_n};
            press <= 1'b0;
            if (pressed_s == btn_state) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_state <= pressed_s;
                press     <= pressed_s;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_irq_conditioner.sv
// Debounced button to level IRQ for the MSS, held until acknowledged; counts missed presses.
// Define GPIO_IRQ_TIMEOUT_EN to build the forced drop after ACK_TIMEOUT_CYCLES in REQ.
module gpio_irq_conditioner
    import gpio_irq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = 500000,
    parameter int unsigned ACK_TIMEOUT_CYCLES = 50000000,
    parameter int unsigned MISS_CNT_W         = MISS_CNT_W_DEF
) (
    input  logic                  CLK_BASE,
    input  logic                  RESET,
    input  logic                  BTN_N,
    input  logic                  MSS_ACK,
    output logic                  IRQ_OUT,
    output logic                  BTN_STATE,
    output logic [MISS_CNT_W-1:0] MISS_COUNT,
    output logic                  TIMEOUT_FLAG
);

    logic   press;
    logic   [1:0] ack_sync;
    logic   ack_prev;
    logic   ack_s;
    logic   ack_rise;
    state_t state;

    gpio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (CLK_BASE),
        .rst       (RESET),
        .btn_n     (BTN_N),
        .btn_state (BTN_STATE),
        .press     (press)
    );

    assign ack_s    = ack_sync[1];
    assign ack_rise = ack_s & ~ack_prev;

`ifdef GPIO_IRQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(ACK_TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign TIMEOUT_FLAG = 1'b0;
`endif

    // Request FSM; IRQ_OUT is registered and high only in REQ.
    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            ack_sync   <= 2'b00;
            ack_prev   <= 1'b0;
            state      <= IDLE;
            IRQ_OUT    <= 1'b0;
            MISS_COUNT <= '0;
`ifdef GPIO_IRQ_TIMEOUT_EN
            to_cnt       <= '0;
            TIMEOUT_FLAG <= 1'b0;
`endif
        end else begin
            ack_sync <= {ack_sync[0], MSS_ACK};
            ack_prev <= ack_s;

            if (press && (state != IDLE) && (MISS_COUNT != '1)) begin
                MISS_COUNT <= MISS_COUNT + MISS_CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (press) begin
                        state   <= REQ;
                        IRQ_OUT <= 1'b1;
`ifdef GPIO_IRQ_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end
                end
                REQ: begin
                    if (ack_rise) begin
                        state   <= WAIT_REL;
                        IRQ_OUT <= 1'b0;
`ifdef GPIO_IRQ_TIMEOUT_EN
                        TIMEOUT_FLAG <= 1'b0;
`endif
                    end
`ifdef GPIO_IRQ_TIMEOUT_EN
                    else if (to_cnt == TO_W'(ACK_TIMEOUT_CYCLES - 1)) begin
                        state        <= ack_s ? WAIT_REL : IDLE;
                        IRQ_OUT      <= 1'b0;
                        TIMEOUT_FLAG <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                WAIT_REL: begin
                    if (!ack_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    IRQ_OUT <= 1'b0;
                end
            endcase
        end
    end

endmodule
